// File: rtl/vscale_vred_xvec_pkg.sv
// vscale_vred_xvec_pkg: shared parameters, reduction op and FSM state encodings
package vscale_vred_xvec_pkg;
   localparam int VRED_LANES   = 32;
   localparam int VRED_XPR_LEN = 32;
   localparam int VRED_LPC     = 4;
   localparam int VRED_OP_WIDTH = 3;
   typedef enum logic [VRED_OP_WIDTH-1:0] {
      OP_SUM  = 3'd0,
      OP_AND  = 3'd1,
      OP_OR   = 3'd2,
      OP_XOR  = 3'd3,
      OP_MIN  = 3'd4,
      OP_MINU = 3'd5,
      OP_MAX  = 3'd6,
      OP_MAXU = 3'd7
   } op_e;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;
endpackage

// File: rtl/vscale_vred_lane_op_xvec.sv
// vscale_vred_lane_op_xvec: combinational two-operand reduction op plus identity generator
module vscale_vred_lane_op_xvec
   import vscale_vred_xvec_pkg::*;
#(
   parameter int W = VRED_XPR_LEN
) (
   input  op_e          op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y,
   output logic [W-1:0] ident
);
   // identity depends on op only, so callers may use it to mask this op's own b input
   assign ident = (op == OP_AND || op == OP_MINU) ? {W{1'b1}} :
                  (op == OP_MIN) ? {1'b0, {(W-1){1'b1}}} :
                  (op == OP_MAX) ? {1'b1, {(W-1){1'b0}}} : '0;
   always_comb begin
      y = a + b;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_MIN:  y = ($signed(a) < $signed(b)) ? a : b;
         OP_MINU: y = (a < b) ? a : b;
         OP_MAX:  y = ($signed(a) > $signed(b)) ? a : b;
         OP_MAXU: y = (a > b) ? a : b;
         default: y = a + b;
      endcase
   end
endmodule

// File: rtl/vscale_vred_xvec.sv
// vscale_vred_xvec: sequential vector-to-scalar reduction, LANES_PER_CYCLE lanes folded per cycle
module vscale_vred_xvec
   import vscale_vred_xvec_pkg::*;
#(
   parameter int LANES           = VRED_LANES,
   parameter int XPR_LEN         = VRED_XPR_LEN,
   parameter int LANES_PER_CYCLE = VRED_LPC
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [2:0]               req_op,
   input  logic [LANES*XPR_LEN-1:0] req_vec,
   input  logic [LANES-1:0]         req_mask,
   input  logic [XPR_LEN-1:0]       req_seed,
   input  logic                     kill,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [XPR_LEN-1:0]       resp_data,
   output logic                     busy
);
   localparam int NGROUPS = LANES / LANES_PER_CYCLE;
   localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
   state_e                   state;
   op_e                      op_q;
   logic [LANES*XPR_LEN-1:0] vec_q;
   logic [LANES-1:0]         mask_q;
   logic [XPR_LEN-1:0]       acc, acc_next, ident;
   logic [GW-1:0]            grp;
   assign req_ready = (state == ST_IDLE) && !kill;
   // operand register shifts down each RUN cycle, so the current group is always lanes 0..LPC-1
   for (genvar k = 0; k < LANES_PER_CYCLE; k++) begin : g
      logic [XPR_LEN-1:0] a, b, y, id;
      if (k == 0) begin : h
         assign a = ident;
      end else begin : h
         assign a = g[k-1].y;
      end
      assign b = mask_q[k] ? vec_q[k*XPR_LEN +: XPR_LEN] : id;
      vscale_vred_lane_op_xvec #(.W(XPR_LEN)) u_lane (
         .op(op_q), .a(a), .b(b), .y(y), .ident(id)
      );
   end
   vscale_vred_lane_op_xvec #(.W(XPR_LEN)) u_acc (
      .op(op_q), .a(acc), .b(g[LANES_PER_CYCLE-1].y), .y(acc_next), .ident(ident)
   );
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         op_q       <= OP_SUM;
         vec_q      <= '0;
         mask_q     <= '0;
         acc        <= '0;
         grp        <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         busy       <= 1'b0;
      end else if (kill) begin
         state      <= ST_IDLE;
         grp        <= '0;
         resp_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (req_valid) begin
               state  <= ST_RUN;
               op_q   <= op_e'(req_op);
               vec_q  <= req_vec;
               mask_q <= req_mask;
               acc    <= req_seed;
               grp    <= '0;
               busy   <= 1'b1;
            end
            ST_RUN: begin
               acc    <= acc_next;
               vec_q  <= vec_q >> (LANES_PER_CYCLE*XPR_LEN);
               mask_q <= mask_q >> LANES_PER_CYCLE;
               grp    <= grp + 1'b1;
               if (grp == GW'(NGROUPS-1)) begin
                  state      <= ST_DONE;
                  resp_valid <= 1'b1;
                  resp_data  <= acc_next;
               end
            end
            ST_DONE: if (resp_ready) begin
               state      <= ST_IDLE;
               resp_valid <= 1'b0;
               busy       <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vscale_vred_xvec.sv
// tb_vscale_vred_xvec: directed vectors, expected results queued at issue and checked by a response monitor
module tb_vscale_vred_xvec;
   import vscale_vred_xvec_pkg::*;
   logic          clk = 1'b0, reset_n = 1'b1, req_valid = 1'b0, kill = 1'b0, resp_ready = 1'b1;
   logic [2:0]    req_op = '0;
   logic [1023:0] req_vec = '0;
   logic [31:0]   req_mask = '0, req_seed = '0;
   logic          req_ready, resp_valid, busy;
   logic [31:0]   resp_data, mon_exp;
   logic [31:0]   sb[$];
   int            compared = 0, mismatched = 0;

   vscale_vred_xvec dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_vec(req_vec), .req_mask(req_mask), .req_seed(req_seed),
      .kill(kill), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: every accepted response is matched against the oldest queued expectation
   always @(negedge clk) begin
      if (reset_n && resp_valid && resp_ready) begin
         compared++;
         if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL resp_unexpected: got %h expected no response", resp_data);
         end else begin
            mon_exp = sb.pop_front();
            if (resp_data !== mon_exp) begin
               mismatched++;
               $display("FAIL resp_data: got %h expected %h", resp_data, mon_exp);
            end
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [1023:0] vec,
                        input logic [31:0] mask, input logic [31:0] seed);
      int t = 0;
      while (!req_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_op = op; req_vec = vec; req_mask = mask; req_seed = seed;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_op    = 3'($urandom);
      req_vec   = {32{$urandom()}};
      req_mask  = $urandom;
      req_seed  = $urandom;
      check("busy_after_accept", 32'(busy), 32'd1);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!resp_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("latency", 32'(n), 32'd8);
   endtask

   task automatic expect_resp(input logic [31:0] exp);
      int n;
      sb.push_back(exp);
      wait_valid(n);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1023:0] v;
      logic [31:0]   d;
      int            n;
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_data", resp_data, 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < 32; i++) v[i*32 +: 32] = 32'(i + 1);
      issue(OP_SUM, v, 32'hFFFF_FFFF, 32'd10);
      expect_resp(32'd538);

      for (int i = 0; i < 32; i++) v[i*32 +: 32] = 32'd3;
      v[5*32 +: 32] = 32'hFFFF_FFF0;
      issue(OP_MIN, v, ~(32'd1 << 5), 32'h7FFF_FFFF);
      expect_resp(32'd3);
      issue(OP_MINU, v, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      expect_resp(32'd3);

      issue(OP_MAX, v, 32'h0, 32'hDEAD_BEEF);
      expect_resp(32'hDEAD_BEEF);

      for (int i = 0; i < 32; i++) v[i*32 +: 32] = 32'hFFFF_FFFF;
      v[31*32 +: 32] = 32'h0F0F_0F0F;
      issue(OP_AND, v, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      expect_resp(32'h0F0F_0F0F);

      for (int i = 0; i < 32; i++) v[i*32 +: 32] = 32'hFFFF_FFFF;
      issue(OP_SUM, v, 32'hFFFF_FFFF, 32'd32);
      expect_resp(32'd0);

      for (int i = 0; i < 32; i++) v[i*32 +: 32] = 32'd1 << i;
      issue(OP_OR, v, 32'h0000_FFFF, 32'h8000_0000);
      expect_resp(32'h8000_FFFF);

      for (int i = 0; i < 32; i++) v[i*32 +: 32] = 32'(i + 1);
      issue(OP_XOR, v, 32'hFFFF_FFFF, 32'h100);
      expect_resp(32'h120);

      for (int i = 0; i < 32; i++) v[i*32 +: 32] = 32'(i - 16);
      issue(OP_MAXU, v, 32'hFFFF_FFFF, 32'd0);
      expect_resp(32'hFFFF_FFFF);

      resp_ready = 1'b0;
      issue(OP_MAX, v, 32'hFFFF_FFFF, 32'h8000_0000);
      sb.push_back(32'd15);
      wait_valid(n);
      d = resp_data;
      repeat (5) begin
         @(posedge clk); #1;
         check("bp_resp_valid", 32'(resp_valid), 32'd1);
         check("bp_resp_data", resp_data, d);
         check("bp_req_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_released_valid", 32'(resp_valid), 32'd0);
      check("bp_released_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < 32; i++) v[i*32 +: 32] = 32'(i + 1);
      issue(OP_SUM, v, 32'hFFFF_FFFF, 32'd10);
      repeat (3) begin
         @(posedge clk); #1;
      end
      kill = 1'b1; req_valid = 1'b1;
      check("kill_req_ready_run", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      kill = 1'b0; req_valid = 1'b0;
      check("kill_busy", 32'(busy), 32'd0);
      check("kill_resp_valid", 32'(resp_valid), 32'd0);
      kill = 1'b1; req_valid = 1'b1;
      check("kill_req_ready_idle", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      kill = 1'b0; req_valid = 1'b0;
      check("kill_idle_not_accepted", 32'(busy), 32'd0);

      issue(OP_XOR, v, 32'hFFFF_FFFF, 32'h5);
      repeat (2) begin
         @(posedge clk); #1;
      end
      reset_n = 1'b0;
      #1;
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_mid_resp_data", resp_data, 32'd0);
      check("rst_mid_req_ready", 32'(req_ready), 32'd1);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      repeat (12) begin
         @(posedge clk); #1;
      end
      check("idle_after_abort", 32'(busy), 32'd0);

      issue(OP_SUM, v, 32'hFFFF_FFFF, 32'd10);
      expect_resp(32'd538);

      repeat (3) @(posedge clk);
      #1 check("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/vscale_vred_xvec.md
# vscale_vred_xvec

Sequential vector-to-scalar reduction unit for the xvec extension. It is the inverse path to the source-operand broadcast. It accepts a 32-lane vector operand, a scalar seed and a lane mask. It folds the lanes into one XPR_LEN scalar over several cycles, a fixed number of lanes per cycle. The result is returned through a valid/ready handshake to the scalar writeback path. It sits beside the vector ALU and drives the scalar register-file write data for reduction instructions.

## Interface
- LANES, 32, number of vector lanes; must equal the xvec register width in lanes.
- XPR_LEN, 32, lane and scalar width in bits.
- LANES_PER_CYCLE, 4, lanes folded per cycle; must divide LANES. NGROUPS = LANES/LANES_PER_CYCLE.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  reduction request valid.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_op  in  3  reduction operation: 0 SUM, 1 AND, 2 OR, 3 XOR, 4 MIN (signed), 5 MINU, 6 MAX (signed), 7 MAXU.
- req_vec  in  LANES*XPR_LEN  vector operand; lane i = bits [i*XPR_LEN +: XPR_LEN].
- req_mask  in  LANES  lane enable; 0 = lane contributes the op identity.
- req_seed  in  XPR_LEN  initial accumulator value (scalar rs1).
- kill  in  1  synchronous pipeline flush; aborts any operation.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  XPR_LEN  reduction result.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready = !kill.
  - On req_valid && req_ready: capture op, vec and mask; set acc = seed and grp = 0; go to RUN.
- RUN:
  - Each cycle, acc = op(acc, fold of lanes grp*LPC..grp*LPC+LPC-1). Masked-off lanes are replaced by the identity.
  - grp increments. After folding grp = NGROUPS-1, go to DONE.
- DONE:
  - resp_valid = 1 and resp_data = acc.
  - On resp_ready, go to IDLE.
  - resp_data is held stable while resp_valid && !resp_ready.
- Identities:
  - SUM/OR/XOR/MAXU: 0.
  - AND/MINU: all ones.
  - MIN: 0x7FFF_FFFF.
  - MAX: 0x8000_0000 (XPR_LEN-scaled).
- Arithmetic:
  - SUM wraps modulo 2^XPR_LEN; no carry out.
  - MIN/MAX compare two's complement; MINU/MAXU compare unsigned.
- All-zero mask: result equals seed.
- Captured operands are registered. Inputs may change after acceptance without effect.
- kill has the highest priority. From any state, the next state is IDLE, resp_valid drops and grp clears. A request presented in the same cycle as kill is not accepted.
- req_ready is low in RUN and DONE, so there is no back-to-back overlap.

## Timing
- Reset values:
  - state IDLE, grp 0, acc 0.
  - resp_valid 0, resp_data 0, busy 0.
  - req_ready 1 (combinational, with kill low).
- Acceptance at edge E. Groups are folded at edges E+1..E+NGROUPS. resp_valid is high in the cycle after edge E+NGROUPS.
- Latency from acceptance edge to first resp_valid cycle is NGROUPS cycles (8 at defaults).
- Minimum initiation interval is NGROUPS+2 cycles: the response handshake and the IDLE cycle.
- Reset asserted mid-operation returns to reset values immediately, with no response.
- resp_valid, resp_data and busy are registered outputs. req_ready depends combinationally only on state and kill.

## Structure
- The following go in xvec/xvec_defines.vh, shared with the decoder:
  - `VRED_OP_WIDTH and the eight `VRED_OP_* encodings.
  - State encodings `VRED_ST_IDLE/RUN/DONE.
- Sub-module vscale_vred_lane_op_xvec is a combinational two-operand op plus identity generator. It is instantiated LANES_PER_CYCLE times as a fold chain/tree plus once for the accumulator.
- The top module holds the FSM, group counter, operand register and accumulator.

## Test plan
- SUM, all lanes i = i+1, mask all ones, seed 10 -> resp_data = 538, resp_valid exactly 8 cycles after acceptance.
- MIN signed, lane 5 = 0xFFFF_FFF0, others 3, mask excludes lane 5, seed 0x7FFF_FFFF -> 3. Same vector with MINU, full mask -> 3.
- MAX, mask = 0, seed 0xDEAD_BEEF -> 0xDEAD_BEEF. AND with full mask, lanes all 0xFFFF_FFFF except lane 31 = 0x0F0F_0F0F -> 0x0F0F_0F0F.
- SUM overflow: all lanes 0xFFFF_FFFF, seed 32 -> 0 (wrap).
- Backpressure: resp_ready held low 5 cycles -> resp_valid and resp_data stable. req_ready low throughout, accepted on first resp_ready.
- kill asserted in the 4th RUN cycle, then reset_n pulsed during a later RUN -> no response either time. Next request completes correctly; req_ready low in the kill cycle.
